// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  // Bit positions inside load_store_info_i
  localparam int unsigned InfoLb  = 7;
  localparam int unsigned InfoLh  = 6;
  localparam int unsigned InfoLw  = 5;
  localparam int unsigned InfoLbu = 4;
  localparam int unsigned InfoLhu = 3;
  localparam int unsigned InfoSb  = 2;
  localparam int unsigned InfoSh  = 1;
  localparam int unsigned InfoSw  = 0;

  localparam int unsigned TimeoutDefault = 255;

  // Keep only the highest set bit so a malformed select still decodes to one op
  function automatic logic [7:0] info_prio(input logic [7:0] info);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (info[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Picks the addressed byte/half out of a read word and sign/zero-extends it.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       offset,
  input  size_e            size,
  input  logic             sign_ext,
  output logic [WIDTH-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select and extension
  always_comb begin
    byte_v = 8'(rdata >> {offset, 3'b000});
    half_v = 16'(rdata >> {offset, 3'b000});
    data   = rdata;
    case (size)
      SzByte:  data = {{(WIDTH-8){sign_ext & byte_v[7]}}, byte_v};
      SzHalf:  data = {{(WIDTH-16){sign_ext & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding data-bus access with watchdog.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [7:0]       load_store_info_i,
  input  logic [WIDTH-1:0] mem_addr_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [WIDTH-1:0] dmem_addr_o,
  output logic [3:0]       dmem_wstrb_o,
  output logic [WIDTH-1:0] dmem_wdata_o,
  input  logic             dmem_gnt_i,
  input  logic             dmem_rvalid_i,
  input  logic [WIDTH-1:0] dmem_rdata_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] load_data_o,
  output logic             load_valid_o,
  output logic             misalign_o,
  output logic             bus_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [3:0]       wstrb;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             bus_err;
  logic             op_load;
  logic             op_signed;
  size_e            op_size;
  logic [1:0]       op_off;

  logic [7:0]       sel;
  logic             any_op;
  logic             is_load;
  logic             is_store;
  logic             is_signed;
  size_e            size;
  logic             aligned;
  logic             start;
  logic [3:0]       new_wstrb;
  logic [WIDTH-1:0] new_wdata;
  logic [WIDTH-1:0] ext_data;
  logic             last_cycle;

  // Decode the incoming instruction: op size, alignment and store lanes
  always_comb begin
    sel       = info_prio(load_store_info_i);
    any_op    = |load_store_info_i;
    is_load   = sel[InfoLb] | sel[InfoLh] | sel[InfoLw] | sel[InfoLbu] | sel[InfoLhu];
    is_store  = sel[InfoSb] | sel[InfoSh] | sel[InfoSw];
    is_signed = sel[InfoLb] | sel[InfoLh];
    if (sel[InfoLb] | sel[InfoLbu] | sel[InfoSb]) begin
      size = SzByte;
    end else if (sel[InfoLh] | sel[InfoLhu] | sel[InfoSh]) begin
      size = SzHalf;
    end else begin
      size = SzWord;
    end
    new_wstrb = 4'b0000;
    new_wdata = rs2_data_i;
    case (size)
      SzByte: begin
        aligned   = 1'b1;
        new_wstrb = 4'b0001 << mem_addr_i[1:0];
        new_wdata = {(WIDTH/8){rs2_data_i[7:0]}};
      end
      SzHalf: begin
        aligned   = ~mem_addr_i[0];
        new_wstrb = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        new_wdata = {(WIDTH/16){rs2_data_i[15:0]}};
      end
      default: begin
        aligned   = (mem_addr_i[1:0] == 2'b00);
        new_wstrb = 4'b1111;
        new_wdata = rs2_data_i;
      end
    endcase
    if (!is_store) begin
      new_wstrb = 4'b0000;
    end
    start      = (state == StIdle) && valid_i && any_op && aligned && !rst;
    misalign_o = (state == StIdle) && valid_i && any_op && !aligned && !rst;
    last_cycle = (cnt == CntW'(TIMEOUT - 1));
  end

  lsu_load_ext #(
    .WIDTH(WIDTH)
  ) u_load_ext (
    .rdata   (dmem_rdata_i),
    .offset  (op_off),
    .size    (op_size),
    .sign_ext(op_signed),
    .data    (ext_data)
  );

  // Access FSM with captured bus fields, watchdog and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      req        <= 1'b0;
      we         <= 1'b0;
      addr       <= '0;
      wstrb      <= '0;
      wdata      <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      op_load    <= 1'b0;
      op_signed  <= 1'b0;
      op_size    <= SzByte;
      op_off     <= '0;
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            addr      <= {mem_addr_i[WIDTH-1:2], 2'b00};
            op_off    <= mem_addr_i[1:0];
            we        <= is_store;
            wstrb     <= new_wstrb;
            wdata     <= new_wdata;
            op_load   <= is_load;
            op_signed <= is_signed;
            op_size   <= size;
            cnt       <= '0;
            req       <= 1'b1;
            state     <= StReq;
          end
        end
        StReq: begin
          cnt <= cnt + CntW'(1);
          if (dmem_gnt_i) begin
            req   <= 1'b0;
            state <= op_load ? StWait : StDone;
          end else if (last_cycle) begin
            req     <= 1'b0;
            bus_err <= 1'b1;
            state   <= StIdle;
          end
        end
        StWait: begin
          cnt <= cnt + CntW'(1);
          if (dmem_rvalid_i) begin
            load_data  <= ext_data;
            load_valid <= 1'b1;
            state      <= StDone;
          end else if (last_cycle) begin
            bus_err <= 1'b1;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign stall_o      = start || (state == StReq) || (state == StWait);
  assign dmem_req_o   = req;
  assign dmem_we_o    = we;
  assign dmem_addr_o  = addr;
  assign dmem_wstrb_o = wstrb;
  assign dmem_wdata_o = wdata;
  assign load_data_o  = load_data;
  assign load_valid_o = load_valid;
  assign bus_err_o    = bus_err;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter WIDTH, default 32: data and address width.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles spent in REQ plus WAIT before a bus error is raised.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 valid_i  in  1  an instruction is present at the stage.
REQ-006 load_store_info_i  in  8  one-hot operation select: [7]lb [6]lh [5]lw [4]lbu [3]lhu [2]sb [1]sh [0]sw.
REQ-007 mem_addr_i  in  WIDTH  byte address from the ALU adder.
REQ-008 rs2_data_i  in  WIDTH  store source data.
REQ-009 dmem_req_o / dmem_we_o  out  1/1  bus request / write enable.
REQ-010 dmem_addr_o  out  WIDTH  word-aligned address {addr[31:2],2'b00}.
REQ-011 dmem_wstrb_o / dmem_wdata_o  out  4/WIDTH  byte strobes and lane-replicated store data.
REQ-012 dmem_gnt_i / dmem_rvalid_i / dmem_rdata_i  in  1/1/WIDTH  grant, read-data valid, read word.
REQ-013 stall_o  out  1  freezes the PC and upstream stages while an access is pending.
REQ-014 load_data_o  out  WIDTH  extended load result; load_valid_o  out  1  one-cycle completion pulse for loads.
REQ-015 misalign_o / bus_err_o  out  1/1  one-cycle exception pulses.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DONE.
REQ-017 Access start: IDLE with valid_i, any info bit set and an aligned address -> capture address, type, strobes and data; go to REQ next cycle.
REQ-018 Multiple info bits set: the highest set bit wins (bit 7 first).
REQ-019 Alignment rule: lw/sw need addr[1:0]=0; lh/lhu/sh need addr[0]=0; byte accesses are always aligned.
REQ-020 Misaligned access in IDLE: misalign_o=1 combinationally in that cycle; no request issued; state stays IDLE; stall_o=0.
REQ-021 Store data and strobes:
  - sb: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - sh: wdata={2{rs2[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011.
  - sw: wdata=rs2, wstrb=4'b1111.
  - Loads drive wstrb=0.
REQ-022 REQ: dmem_req_o=1 with all captured fields held stable until dmem_gnt_i is sampled high.
REQ-023 Grant: store -> DONE; load -> WAIT; dmem_req_o drops the cycle after the grant.
REQ-024 WAIT: on dmem_rvalid_i, register the extracted and extended word into load_data_o, then go to DONE. rvalid outside WAIT is ignored.
REQ-025 Load extraction: byte/half = rdata >> (8*addr[1:0]); lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
REQ-026 DONE: load_valid_o=1 for one cycle on loads (0 on stores); stall_o=0; IDLE next cycle. Minimum latency is 3 cycles for a store and 4 for a load with immediate grant and rvalid.
REQ-027 stall_o = (IDLE and access starting) or REQ or WAIT.
REQ-028 Watchdog: counter clears on entering REQ and increments each cycle in REQ or WAIT. When it reaches TIMEOUT, bus_err_o pulses one cycle, the FSM returns to IDLE, and dmem_req_o drops.
REQ-029 load_data_o holds its last value until the next load completes.

Reset
REQ-030 rst, including mid-access, forces at the next edge: state=IDLE, counter=0, load_data_o=0, and all pulse, request and stall outputs 0. A late rvalid after reset is ignored.
REQ-031 Reset value of every output is 0.

Structure
REQ-032 lsu_pkg holds the FSM state enum, the load_store_info bit indices and the TIMEOUT default.
REQ-033 Sub-module lsu_load_ext: purely combinational byte/half extraction and sign/zero extension.

Verification
REQ-034 sb addr=0x1003, rs2=0x000000A5, immediate gnt -> dmem_addr_o=0x1000, wstrb=4'b1000, wdata=0xA5A5A5A5; stall_o high for 2 cycles.
REQ-035 lh addr=0x2002, rdata=0x80011234 -> load_data_o=0xFFFF8001; lhu on the same word -> 0x00008001; load_valid_o pulses once per load.
REQ-036 lw addr=0x3001 -> misalign_o=1 for one cycle, dmem_req_o never asserted, stall_o=0.
REQ-037 gnt held low for 3 cycles -> req, address and data stable across all of them; one access completes after the grant.
REQ-038 Load with gnt given and rvalid withheld, TIMEOUT=8 -> bus_err_o pulses exactly once, then IDLE, and no load_valid_o pulse.
REQ-039 rst asserted in WAIT followed by a late rvalid -> IDLE, all outputs 0, load_data_o unchanged by the rvalid.
